console_stream_bridge: RTL

Parametrised, buffered bridge between the processor's console registers and the host-side console handshakes (CONSOLE_OUT ready/valid, CONSOLE_IN valid/ack). It replaces single-byte, unbuffered console hand-off with independent TX and RX first-word-fall-through FIFOs of configurable width and depth, occupancy counters and a sticky overflow flag. It sits inside Wrapper, between the memory-mapped console decode and the top-level console ports.

---
 rtl/console_stream_bridge.sv | 128 ++++++++++++
 1 files changed

// File: rtl/console_stream_bridge.sv
// Buffered console bridge: TX FIFO toward the host (ready/valid) and
// RX FIFO from the host (valid/ack), with occupancy counts and a sticky TX overflow flag.
module console_stream_bridge #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TX_DEPTH   = 16,
  parameter int unsigned RX_DEPTH   = 16
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        TX_WE,
  input  logic [DATA_WIDTH-1:0]       TX_DATA,
  input  logic                        RX_RD,
  output logic [DATA_WIDTH-1:0]       RX_DATA,
  output logic [$clog2(TX_DEPTH):0]   TX_COUNT,
  output logic [$clog2(RX_DEPTH):0]   RX_COUNT,
  output logic                        TX_OVF,
  input  logic                        CLR_FLAGS,
  output logic [DATA_WIDTH-1:0]       CONSOLE_OUT,
  output logic                        CONSOLE_OUT_valid,
  input  logic                        CONSOLE_OUT_ready,
  input  logic [DATA_WIDTH-1:0]       CONSOLE_IN,
  input  logic                        CONSOLE_IN_valid,
  output logic                        CONSOLE_IN_ack
);

  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned TX_CW = TX_AW + 1;
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned RX_CW = RX_AW + 1;

  typedef enum logic {RX_IDLE, RX_WAIT_LOW} rx_state_t;

  // TX FIFO storage and control
  logic [DATA_WIDTH-1:0] tx_mem [TX_DEPTH];
  logic [TX_AW-1:0]      tx_wr_ptr;
  logic [TX_AW-1:0]      tx_rd_ptr;
  logic                  tx_full;
  logic                  tx_push;
  logic                  tx_pop;

  // RX FIFO storage and control
  logic [DATA_WIDTH-1:0] rx_mem [RX_DEPTH];
  logic [RX_AW-1:0]      rx_wr_ptr;
  logic [RX_AW-1:0]      rx_rd_ptr;
  logic                  rx_full;
  logic                  rx_push;
  logic                  rx_pop;
  rx_state_t             rx_state;

  // Full is judged on the pre-edge count so a same-cycle pop never admits a push.
  assign tx_full = (TX_COUNT == TX_CW'(TX_DEPTH));
  assign tx_push = TX_WE && !tx_full;
  assign tx_pop  = CONSOLE_OUT_valid && CONSOLE_OUT_ready;

  assign rx_full = (RX_COUNT == RX_CW'(RX_DEPTH));
  assign rx_push = (rx_state == RX_IDLE) && CONSOLE_IN_valid && !rx_full;
  assign rx_pop  = RX_RD && (RX_COUNT != '0);

  // Heads are derived from FIFO state only; storage is not reset, so gate on occupancy.
  assign CONSOLE_OUT_valid = (TX_COUNT != '0);
  assign CONSOLE_OUT       = CONSOLE_OUT_valid ? tx_mem[tx_rd_ptr] : '0;
  assign RX_DATA           = (RX_COUNT != '0) ? rx_mem[rx_rd_ptr] : '0;

  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= TX_DATA;
    if (rx_push) rx_mem[rx_wr_ptr] <= CONSOLE_IN;
  end

  // TX pointers, occupancy and sticky overflow
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      TX_COUNT  <= '0;
      TX_OVF    <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   TX_COUNT <= TX_COUNT + TX_CW'(1);
        2'b01:   TX_COUNT <= TX_COUNT - TX_CW'(1);
        default: TX_COUNT <= TX_COUNT;
      endcase
      if (TX_WE && tx_full) TX_OVF <= 1'b1;
      else if (CLR_FLAGS)   TX_OVF <= 1'b0;
    end
  end

  // RX pointers and occupancy
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      RX_COUNT  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   RX_COUNT <= RX_COUNT + RX_CW'(1);
        2'b01:   RX_COUNT <= RX_COUNT - RX_CW'(1);
        default: RX_COUNT <= RX_COUNT;
      endcase
    end
  end

  // Host capture handshake: one ack per offered byte, then wait for valid to drop
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_state       <= RX_IDLE;
      CONSOLE_IN_ack <= 1'b0;
    end else begin
      CONSOLE_IN_ack <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_push) begin
            CONSOLE_IN_ack <= 1'b1;
            rx_state       <= RX_WAIT_LOW;
          end
        end
        RX_WAIT_LOW: begin
          if (!CONSOLE_IN_valid) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule
